// File: rtl/stall_mem_pkg.sv
// Shared types and constants for the multi-cycle stall_mem data memory.
package stall_mem_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam int CNT_W             = 4;
    localparam int DEFAULT_LATENCY   = 4;
    localparam int DEFAULT_ADDR_BITS = 8;

endpackage

// File: rtl/stall_mem_array.sv
// Synchronous 2^ADDR_BITS x 16 storage: one write port, one registered read port.
// Contents are not reset; only the read register is.
module stall_mem_array #(
    parameter int ADDR_BITS = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 we_i,
    input  logic                 re_i,
    input  logic [ADDR_BITS-1:0] addr_i,
    input  logic [15:0]          wdata_i,
    output logic [15:0]          rdata_o
);

    logic [15:0] mem_q [2**ADDR_BITS];
    logic [15:0] rdata_q;

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[addr_i] <= wdata_i;
        end
    end

    // Read data is held between loads so DataOut stays stable after Done.
    always_ff @(posedge clk) begin
        if (rst) begin
            rdata_q <= '0;
        end else if (re_i) begin
            rdata_q <= mem_q[addr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/stall_mem.sv
// Multi-cycle data memory responder with Stall/Done handshake and err pulse.
// Define STALL_MEM_ALIGN_CHECK_EN to reject requests with Addr[0]=1.
module stall_mem
    import stall_mem_pkg::*;
#(
    parameter int LATENCY   = DEFAULT_LATENCY,
    parameter int ADDR_BITS = DEFAULT_ADDR_BITS
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] Addr,
    input  logic [15:0] DataIn,
    input  logic        Rd,
    input  logic        Wr,
    output logic [15:0] DataOut,
    output logic        Done,
    output logic        Stall,
    output logic        err
);

    if (LATENCY < 2 || LATENCY > 15) begin : g_bad_latency
        $error("stall_mem: LATENCY must be in 2..15");
    end

    state_e                 state_q;
    logic [CNT_W-1:0]       cnt_q;
    logic [ADDR_BITS-1:0]   addr_q;
    logic [15:0]            data_q;
    logic                   isWrite_q;
    logic                   done_q;
    logic                   err_q;

    logic                   misaligned;
    logic                   reqIllegal;
    logic                   reqValid;
    logic                   lastBusy;
    logic                   commitWr;
    logic                   loadRd;
    logic                   unusedAddrBits;

`ifdef STALL_MEM_ALIGN_CHECK_EN
    assign misaligned = Addr[0];
`else
    assign misaligned = 1'b0;
`endif

    assign unusedAddrBits = ^Addr;

    assign reqIllegal = (Rd && Wr) || (misaligned && (Rd || Wr));
    assign reqValid   = (Rd ^ Wr) && !reqIllegal;

    // The access happens on the edge that leaves BUSY; reset on that edge aborts it.
    assign lastBusy = (state_q == BUSY) && (cnt_q == CNT_W'(1));
    assign commitWr = lastBusy &&  isWrite_q && !rst;
    assign loadRd   = lastBusy && !isWrite_q && !rst;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            addr_q    <= '0;
            data_q    <= '0;
            isWrite_q <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            done_q <= 1'b0;
            err_q  <= 1'b0;
            case (state_q)
                BUSY: begin
                    cnt_q <= cnt_q - 1'b1;
                    if (cnt_q == CNT_W'(1)) begin
                        state_q <= DONE;
                        done_q  <= 1'b1;
                    end
                end
                default: begin
                    // IDLE and DONE both accept; requests seen while BUSY are dropped.
                    if (reqValid) begin
                        state_q   <= BUSY;
                        cnt_q     <= CNT_W'(LATENCY - 1);
                        addr_q    <= Addr[ADDR_BITS:1];
                        data_q    <= DataIn;
                        isWrite_q <= Wr;
                    end else begin
                        state_q <= IDLE;
                        err_q   <= reqIllegal;
                    end
                end
            endcase
        end
    end

    stall_mem_array #(
        .ADDR_BITS(ADDR_BITS)
    ) u_array (
        .clk     (clk),
        .rst     (rst),
        .we_i    (commitWr),
        .re_i    (loadRd),
        .addr_i  (addr_q),
        .wdata_i (data_q),
        .rdata_o (DataOut)
    );

    assign Done  = done_q;
    assign Stall = (state_q == BUSY);
    assign err   = err_q;

endmodule

// File: tb/tb_stall_mem.sv
// Self-checking bench for stall_mem: cycle-level reference model plus directed scenarios.
// Honours STALL_MEM_ALIGN_CHECK_EN the same way the design does.
module tb_stall_mem;

    localparam int LAT = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] Addr;
    logic [15:0] DataIn;
    logic        Rd;
    logic        Wr;
    logic [15:0] DataOut;
    logic        Done;
    logic        Stall;
    logic        err;

    int checksTotal  = 0;
    int checksPassed = 0;

    always #5 clk = ~clk;

    stall_mem #(
        .LATENCY   (LAT),
        .ADDR_BITS (8)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .Addr    (Addr),
        .DataIn  (DataIn),
        .Rd      (Rd),
        .Wr      (Wr),
        .DataOut (DataOut),
        .Done    (Done),
        .Stall   (Stall),
        .err     (err)
    );

`ifdef STALL_MEM_ALIGN_CHECK_EN
    localparam bit ALIGN_CHECK = 1'b1;
`else
    localparam bit ALIGN_CHECK = 1'b0;
`endif

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checksTotal++;
        if (actual === expected) begin
            checksPassed++;
        end else begin
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
        end
    endtask

    // Reference model: an access accepted at the end of cycle c is in flight until
    // cycle c+LAT, where Done is expected; the memory effect lands on entering that cycle.
    logic [15:0] modelMem   [256];
    bit          modelKnown [256];
    bit          modelValid   = 1'b0;
    int          cyc          = 0;
    bit          inFlight     = 1'b0;
    int          doneAt       = 0;
    bit          opWrite      = 1'b0;
    logic [7:0]  opAddr       = '0;
    logic [15:0] opData       = '0;
    logic        expDone      = 1'b0;
    logic        expStall     = 1'b0;
    logic        expErr       = 1'b0;
    logic [15:0] expData      = '0;
    bit          expDataKnown = 1'b0;

    always @(posedge clk) begin
        int nextCyc;
        bit accepting;
        nextCyc = cyc + 1;
        if (rst) begin
            modelValid   = 1'b1;
            inFlight     = 1'b0;
            expData      = 16'h0000;
            expDataKnown = 1'b1;
            expDone      = 1'b0;
            expStall     = 1'b0;
            expErr       = 1'b0;
        end else begin
            accepting = !(inFlight && cyc < doneAt);
            if (inFlight && nextCyc == doneAt) begin
                if (opWrite) begin
                    modelMem[opAddr]   = opData;
                    modelKnown[opAddr] = 1'b1;
                end else begin
                    expData      = modelMem[opAddr];
                    expDataKnown = modelKnown[opAddr];
                end
            end
            expErr = 1'b0;
            if (accepting) begin
                inFlight = 1'b0;
                if ((Rd && Wr) || (ALIGN_CHECK && Addr[0] && (Rd || Wr))) begin
                    expErr = 1'b1;
                end else if (Rd != Wr) begin
                    inFlight = 1'b1;
                    doneAt   = cyc + LAT;
                    opWrite  = Wr;
                    opAddr   = Addr[8:1];
                    opData   = DataIn;
                end
            end
            expStall = inFlight && (nextCyc < doneAt);
            expDone  = inFlight && (nextCyc == doneAt);
        end
        cyc = nextCyc;
    end

    // Compare every cycle, mid-cycle, once the model has seen reset.
    always @(negedge clk) begin
        if (modelValid) begin
            checkOutput("model_Done",  {31'd0, Done},  {31'd0, expDone});
            checkOutput("model_Stall", {31'd0, Stall}, {31'd0, expStall});
            checkOutput("model_err",   {31'd0, err},   {31'd0, expErr});
            if (expDataKnown) begin
                checkOutput("model_DataOut", {16'd0, DataOut}, {16'd0, expData});
            end
        end
    end

    // Present a request at the current negedge and hold it until Done is seen.
    // Returns at the negedge of the Done cycle with the request still driven.
    task automatic applyStimulus(input logic rd, input logic wr, input logic [15:0] a,
                                 input logic [15:0] d, output int lat);
        Rd     = rd;
        Wr     = wr;
        Addr   = a;
        DataIn = d;
        lat    = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (Done !== 1'b1 && lat < 40);
        if (lat >= 40) begin
            checkOutput("done_timeout", 32'd0, 32'd1);
        end
    endtask

    task automatic idle(input int n);
        Rd = 1'b0;
        Wr = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    initial begin
        int lat;
        Rd     = 1'b0;
        Wr     = 1'b0;
        Addr   = '0;
        DataIn = '0;
        rst    = 1'b1;
        repeat (2) @(negedge clk);
        checkOutput("reset_DataOut", {16'd0, DataOut}, 32'h0);
        checkOutput("reset_Done",    {31'd0, Done},    32'h0);
        checkOutput("reset_Stall",   {31'd0, Stall},   32'h0);
        checkOutput("reset_err",     {31'd0, err},     32'h0);
        rst = 1'b0;
        idle(1);

        // Known background contents
        applyStimulus(1'b0, 1'b1, 16'h0020, 16'h7777, lat);
        idle(1);
        applyStimulus(1'b0, 1'b1, 16'h0030, 16'hAAAA, lat);
        idle(1);

        // Write then read-after-write issued in the write's Done cycle
        applyStimulus(1'b0, 1'b1, 16'h0010, 16'hBEEF, lat);
        checkOutput("wr_done_cycle", lat, 32'd4);
        applyStimulus(1'b1, 1'b0, 16'h0010, 16'h0000, lat);
        checkOutput("raw_done_cycle", lat, 32'd4);
        checkOutput("raw_data", {16'd0, DataOut}, 32'hBEEF);
        idle(2);
        checkOutput("data_held", {16'd0, DataOut}, 32'hBEEF);

        // Write pulse while busy on a read is ignored
        Rd = 1'b1; Wr = 1'b0; Addr = 16'h0010; DataIn = 16'h0000;
        @(negedge clk);
        @(negedge clk);
        Rd = 1'b0; Wr = 1'b1; Addr = 16'h0020; DataIn = 16'h1234;
        @(negedge clk);
        Rd = 1'b1; Wr = 1'b0; Addr = 16'h0010; DataIn = 16'h0000;
        @(negedge clk);
        checkOutput("busy_read_done", {31'd0, Done}, 32'h1);
        checkOutput("busy_read_data", {16'd0, DataOut}, 32'hBEEF);
        idle(1);
        applyStimulus(1'b1, 1'b0, 16'h0020, 16'h0000, lat);
        checkOutput("ignored_write", {16'd0, DataOut}, 32'h7777);
        idle(1);

        // Rd and Wr together
        Rd = 1'b1; Wr = 1'b1; Addr = 16'h0010; DataIn = 16'h0000;
        @(negedge clk);
        checkOutput("both_err",   {31'd0, err},   32'h1);
        checkOutput("both_stall", {31'd0, Stall}, 32'h0);
        checkOutput("both_done",  {31'd0, Done},  32'h0);
        Rd = 1'b0; Wr = 1'b0;
        @(negedge clk);
        checkOutput("err_one_cycle", {31'd0, err}, 32'h0);
        applyStimulus(1'b1, 1'b0, 16'h0010, 16'h0000, lat);
        checkOutput("both_no_write", {16'd0, DataOut}, 32'hBEEF);
        idle(1);

        // Reset in cycle 2 of a write aborts it
        Rd = 1'b0; Wr = 1'b1; Addr = 16'h0030; DataIn = 16'h5555;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        checkOutput("abort_Done",    {31'd0, Done},    32'h0);
        checkOutput("abort_Stall",   {31'd0, Stall},   32'h0);
        checkOutput("abort_err",     {31'd0, err},     32'h0);
        checkOutput("abort_DataOut", {16'd0, DataOut}, 32'h0);
        rst = 1'b0;
        idle(1);
        applyStimulus(1'b1, 1'b0, 16'h0030, 16'h0000, lat);
        checkOutput("abort_no_commit", {16'd0, DataOut}, 32'hAAAA);
        idle(1);

        // Odd byte address
`ifdef STALL_MEM_ALIGN_CHECK_EN
        Rd = 1'b1; Wr = 1'b0; Addr = 16'h0011; DataIn = 16'h0000;
        @(negedge clk);
        checkOutput("misaligned_err", {31'd0, err}, 32'h1);
        idle(LAT + 2);
        checkOutput("misaligned_no_done", {31'd0, Done}, 32'h0);
`else
        applyStimulus(1'b1, 1'b0, 16'h0011, 16'h0000, lat);
        checkOutput("odd_addr_done_cycle", lat, 32'd4);
        checkOutput("odd_addr_data", {16'd0, DataOut}, 32'hBEEF);
        idle(1);
`endif

        // Three back-to-back reads: Done in cycles 4, 8, 12
        applyStimulus(1'b1, 1'b0, 16'h0010, 16'h0000, lat);
        checkOutput("b2b_lat0", lat, 32'd4);
        checkOutput("b2b_stall0", {31'd0, Stall}, 32'h0);
        checkOutput("b2b_data0", {16'd0, DataOut}, 32'hBEEF);
        applyStimulus(1'b1, 1'b0, 16'h0020, 16'h0000, lat);
        checkOutput("b2b_lat1", lat, 32'd4);
        checkOutput("b2b_stall1", {31'd0, Stall}, 32'h0);
        checkOutput("b2b_data1", {16'd0, DataOut}, 32'h7777);
        applyStimulus(1'b1, 1'b0, 16'h0030, 16'h0000, lat);
        checkOutput("b2b_lat2", lat, 32'd4);
        checkOutput("b2b_stall2", {31'd0, Stall}, 32'h0);
        checkOutput("b2b_data2", {16'd0, DataOut}, 32'hAAAA);
        idle(3);

        $display("%0d/%0d checks passed", checksPassed, checksTotal);
        $finish;
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule

// File: doc/stall_mem.md
# stall_mem

Multi-cycle, word-addressed data memory that acts as the responder for the processor's memory stage. It accepts one read or write request at a time, holds `Stall` high while the access is in flight, and pulses `Done` when read data is valid or a write has committed. It replaces the single-cycle data memory when the pipeline's stall path is exercised against a realistic memory latency.

## Interface
- `LATENCY`, default 4: cycles from request acceptance to `Done`. Legal range is 2..15.
- `ADDR_BITS`, default 8: log2 of the word count. Storage is 2^ADDR_BITS 16-bit words.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `Addr` in 16: byte address. Word index is `Addr[ADDR_BITS:1]`; upper bits are ignored.
- `DataIn` in 16: write data, sampled at acceptance.
- `Rd` in 1: read request.
- `Wr` in 1: write request.
- `DataOut` out 16: read data. Valid while `Done`=1, then held until the next read `Done`.
- `Done` out 1: one-cycle completion pulse.
- `Stall` out 1: an access is in flight and new requests are ignored.
- `err` out 1: one-cycle pulse for an illegal request.

## Operation
- FSM states:
  - IDLE: default state.
  - BUSY: access in flight.
  - DONE: completion cycle.
- Acceptance: a request is accepted at a rising edge when the state is IDLE or DONE and exactly one of `Rd`/`Wr` is high.
  - Accepted request: latch `Addr`, `DataIn` and the op. Load the counter with `LATENCY-1`. Go to BUSY.
- BUSY: decrement the counter each cycle. At count 1, go to DONE.
  - A write commits to the array on that same edge.
  - A read loads `DataOut` from the array on that same edge.
- DONE: `Done`=1 for one cycle. Next state is BUSY if a new request is accepted, otherwise IDLE. This gives back-to-back throughput of one access per `LATENCY` cycles.
- `Stall` = (state == BUSY), decoded from registered state with no combinational input path.
- The initiator holds `Rd`/`Wr`/`Addr`/`DataIn` stable until it sees `Done`. Requests presented while BUSY are ignored; they are not queued and do not raise `err`.
- A second request presented in the DONE cycle is treated as new.
- `Rd`=1 and `Wr`=1 together in an accepting state: not accepted, `err` pulses on the next cycle, state goes to IDLE.
- Array contents are not cleared by `rst`. They power up as X.
- Reset values:
  - state IDLE, counter 0
  - `DataOut`=16'h0000, `Done`=0, `Stall`=0, `err`=0
- `rst` mid-access aborts the access. A pending write is not committed. Outputs take reset values on the next edge.

## Timing
- A request is presented in cycle 0 with the block in IDLE and accepted at the end of cycle 0.
- `Stall`=1 in cycles 1..LATENCY-1.
- `Done`=1 and `Stall`=0 in cycle LATENCY.
- Read-after-write to the same address, issued in the DONE cycle of the write, returns the new data.
- `err` asserts in cycle 1 for a request rejected in cycle 0.

## Configuration
- `STALL_MEM_ALIGN_CHECK_EN` defined:
  - A request with `Addr[0]`=1 in an accepting state is rejected.
  - `err` pulses in the next cycle. No access occurs. State goes to IDLE.
- `STALL_MEM_ALIGN_CHECK_EN` undefined:
  - `Addr[0]` is ignored and the access proceeds normally.
  - `err` is driven only by simultaneous `Rd`/`Wr`.

## Structure
- Shared package `stall_mem_pkg` holds:
  - the state enum (IDLE/BUSY/DONE)
  - the counter width constant (4 bits)
  - the default `LATENCY` and `ADDR_BITS` values
- Sub-module `stall_mem_array`: synchronous 2^ADDR_BITS x 16 storage with one write port and one registered read port, enabled by the FSM's commit/load strobes.
- The top level contains the FSM, the latency counter, the request latches and the `err` logic.

## Test plan
All scenarios use LATENCY=4 and ADDR_BITS=8.
- Write `Addr`=0x0010, `DataIn`=0xBEEF in cycle 0, then read 0x0010 in the write's DONE cycle.
  - Write: `Stall`=1 in cycles 1–3, `Done`=1 in cycle 4.
  - Read: `Done` in cycle 8 with `DataOut`=0xBEEF.
- While BUSY on a read of 0x0010, pulse `Wr` to 0x0020 with 0x1234 in cycle 2.
  - The write is ignored and `err`=0.
  - A later read of 0x0020 returns the prior contents.
- `Rd`=`Wr`=1 in IDLE at cycle 0:
  - `err`=1 in cycle 1 only.
  - `Stall` and `Done` stay 0.
  - Memory is unchanged.
- Assert `rst` in cycle 2 of a write of 0x5555 to 0x0030:
  - All outputs are 0 after the edge.
  - A subsequent read of 0x0030 does not return 0x5555.
- With the macro defined, read `Addr`=0x0011:
  - `err` pulses in cycle 1 and no `Done` follows.
- With the macro undefined, read `Addr`=0x0011:
  - Returns the word at 0x0010 with `Done` in cycle 4.
- Three back-to-back reads, each issued in the previous DONE cycle:
  - `Done` in cycles 4, 8 and 12.
  - `Stall` is never high in a DONE cycle.
